// File: rtl/msp_pkg.sv
// rtl/msp_pkg.sv - shared fetch FSM encoding and PC step
package msp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC = 2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction word/PC storage ring with push, pop and flush
module fetch_fifo #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [SIZE-1:0]            push_word,
    input  logic [SIZE-1:0]            push_pc,
    input  logic                       pop,
    input  logic                       flush,
    output logic [SIZE-1:0]            head_word,
    output logic [SIZE-1:0]            head_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [SIZE-1:0] word_mem [DEPTH];
    logic [SIZE-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_pop;

    assign do_pop = pop && (count != '0);

    // Pointers are PW bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            word_mem[tail] <= push_word;
            pc_mem[tail]   <= push_pc;
        end
    end

    assign head_word = word_mem[head];
    assign head_pc   = pc_mem[head];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FSM feeding a small decode queue
module fetch_queue
    import msp_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SIZE-1:0]            RST_VEC,
    input  logic                       redirect,
    input  logic [SIZE-1:0]            redirect_pc,
    output logic                       mem_req,
    output logic [SIZE-1:0]            mem_addr,
    input  logic                       mem_ack,
    input  logic [SIZE-1:0]            mem_rdata,
    output logic                       dec_valid,
    output logic [SIZE-1:0]            dec_word,
    output logic [SIZE-1:0]            dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL       = CW'(DEPTH);
    localparam logic [SIZE-1:0] ALIGN_MASK = {{(SIZE-1){1'b1}}, 1'b0};

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [SIZE-1:0] fetch_pc;
    logic [SIZE-1:0] pc_next;
    logic [SIZE-1:0] addr_q;
    logic            addr_load;
    logic            push;
    logic            pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // addr_q is separate from fetch_pc so a redirect during DISCARD can
    // retarget fetch_pc while the abandoned request keeps its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RST_VEC & ALIGN_MASK;
            addr_q   <= '0;
        end else begin
            fetch_pc <= pc_next;
            if (addr_load) begin
                addr_q <= fetch_pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        addr_load  = 1'b0;
        push       = 1'b0;
        if (redirect) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end
        case (state)
            ST_IDLE: begin
                if (!redirect && (count < FULL)) begin
                    state_next = ST_REQ;
                    addr_load  = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                    if (!redirect) begin
                        push    = 1'b1;
                        pc_next = fetch_pc + SIZE'(PC_INC);
                    end
                end else if (redirect) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_req   = (state == ST_REQ) || (state == ST_DISCARD);
    assign mem_addr  = addr_q;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready && !redirect;

    fetch_fifo #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_word (mem_rdata),
        .push_pc   (addr_q),
        .pop       (pop),
        .flush     (redirect),
        .head_word (dec_word),
        .head_pc   (dec_pc),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] rst_vec = 16'hC000;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        dec_valid;
    logic [15:0] dec_word;
    logic [15:0] dec_pc;
    logic        dec_ready;
    logic [2:0]  count;

    logic [15:0] rst_vec8 = 16'h0100;
    logic        redirect8;
    logic [15:0] redirect_pc8;
    logic        mem_req8;
    logic [15:0] mem_addr8;
    logic        mem_ack8;
    logic [15:0] mem_rdata8;
    logic        dec_valid8;
    logic [15:0] dec_word8;
    logic [15:0] dec_pc8;
    logic        dec_ready8;
    logic [3:0]  count8;

    assign mem_rdata  = mem_addr  ^ 16'h5A5A;
    assign mem_rdata8 = mem_addr8 ^ 16'h5A5A;

    fetch_queue #(.SIZE(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .RST_VEC(rst_vec),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_word(dec_word), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .count(count)
    );

    fetch_queue #(.SIZE(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .RST_VEC(rst_vec8),
        .redirect(redirect8), .redirect_pc(redirect_pc8),
        .mem_req(mem_req8), .mem_addr(mem_addr8),
        .mem_ack(mem_ack8), .mem_rdata(mem_rdata8),
        .dec_valid(dec_valid8), .dec_word(dec_word8), .dec_pc(dec_pc8),
        .dec_ready(dec_ready8), .count(count8)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] fetched [$];
    logic [15:0] popped8 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (mem_req && mem_ack) fetched.push_back(mem_addr);
        if (dec_valid8 && dec_ready8 && !redirect8) popped8.push_back(dec_pc8);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b0; dec_ready = 1'b0;
        redirect8 = 1'b0; redirect_pc8 = '0; mem_ack8 = 1'b0; dec_ready8 = 1'b0;
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_count", count, 0);

        // fill from C000 with ack tied high, decoder stalled
        rst = 1'b1;
        step();
        check("issue_mem_req", mem_req, 1);
        check("issue_addr", mem_addr, 16'hC000);
        check("pre_ack_dec_valid", dec_valid, 0);
        fetched.delete();
        mem_ack = 1'b1;
        step();
        check("latency_dec_valid", dec_valid, 1);
        check("first_dec_pc", dec_pc, 16'hC000);
        check("first_dec_word", dec_word, 16'h9A5A);
        repeat (12) step();
        check("full_count", count, 4);
        check("full_mem_req", mem_req, 0);
        check("fill_n", fetched.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fill_addr%0d", i), (i < fetched.size()) ? fetched[i] : 16'hxxxx,
                  16'hC000 + 16'(2 * i));

        // one pop from full, then one refill
        fetched.delete();
        check("prepop_dec_pc", dec_pc, 16'hC000);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("pop_count", count, 3);
        check("pop_dec_pc", dec_pc, 16'hC002);
        check("pop_dec_word", dec_word, 16'h9A58);
        repeat (5) step();
        check("refill_n", fetched.size(), 1);
        check("refill_addr", (fetched.size() > 0) ? fetched[0] : 16'hxxxx, 16'hC008);
        check("refill_count", count, 4);

        // redirect to F001 with a pending request
        mem_ack = 1'b0;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        step();
        check("pend_mem_req", mem_req, 1);
        check("pend_addr", mem_addr, 16'hC00A);
        redirect = 1'b1; redirect_pc = 16'hF001;
        step();
        redirect = 1'b0;
        check("disc_count", count, 0);
        check("disc_dec_valid", dec_valid, 0);
        check("disc_mem_req", mem_req, 1);
        check("disc_addr", mem_addr, 16'hC00A);
        step(); step();
        check("disc_hold_req", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("disc_done_req", mem_req, 0);
        check("disc_drop_count", count, 0);
        step();
        check("redir_addr", mem_addr, 16'hF000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("redir_push_count", count, 1);
        check("redir_push_pc", dec_pc, 16'hF000);

        // redirect and ack in the same cycle
        step();
        check("same_pend_addr", mem_addr, 16'hF002);
        redirect = 1'b1; redirect_pc = 16'h1234; mem_ack = 1'b1;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        check("same_count", count, 0);
        check("same_no_discard", mem_req, 0);
        step();
        check("same_next_req", mem_req, 1);
        check("same_next_addr", mem_addr, 16'h1234);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("same_push_pc", dec_pc, 16'h1234);
        check("same_push_word", dec_word, 16'h486E);

        // fetch_pc wrap FFFE -> 0000
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        check("wrap_flush_count", count, 0);
        step();
        check("wrap_addr_hi", mem_addr, 16'hFFFE);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("wrap_dec_pc", dec_pc, 16'hFFFE);
        step();
        check("wrap_addr_lo", mem_addr, 16'h0000);
        check("wrap_req", mem_req, 1);

        // asynchronous reset mid-request
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_count", count, 0);
        check("arst_dec_valid", dec_valid, 0);
        mem_ack = 1'b1;
        step();
        rst = 1'b1; mem_ack = 1'b0;
        step();
        check("arst_first_addr", mem_addr, 16'hC000);
        check("arst_first_req", mem_req, 1);
        check("arst_no_capture", count, 0);

        // DEPTH=8: fill, then drain with refills to wrap the pointers
        mem_ack8 = 1'b1;
        repeat (20) step();
        check("d8_full_count", count8, 8);
        popped8.delete();
        dec_ready8 = 1'b1;
        repeat (24) step();
        dec_ready8 = 1'b0;
        check("d8_pop_n", popped8.size() >= 9, 1);
        for (int i = 0; i < 9; i++)
            check($sformatf("d8_order%0d", i), (i < popped8.size()) ? popped8[i] : 16'hxxxx,
                  16'h0100 + 16'(2 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
